llki_reg_responder: RTL and testbench

Register-side responder that sits directly downstream of the TL-UL register adapter. It consumes the adapter's single-cycle `re`/`we` pulses, holds a bank of byte-maskable 32-bit registers with read-only hardware-status lanes, and returns `rdata`/`ack`/`error` after a programmable number of wait states. This exercises and supports the adapter's delayed-acknowledge path.

---
 rtl/llki_reg_responder.sv | 158 +++++++++++++++
 tb/tb_llki_reg_responder.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/llki_reg_responder.sv
// Register responder behind the TL-UL register adapter: byte-maskable register bank with
// read-only hardware-status lanes, acknowledged after a fixed number of wait states.
module llki_reg_responder #(
    parameter int unsigned         RegAw      = 8,
    parameter int unsigned         RegDw      = 32,
    parameter int unsigned         NumRegs    = 16,
    parameter int unsigned         AckLatency = 1,
    parameter logic [NumRegs-1:0]  RoMask     = '0
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       re_i,
    input  logic                       we_i,
    input  logic [RegAw-1:0]           addr_i,
    input  logic [RegDw-1:0]           wdata_i,
    input  logic [RegDw/8-1:0]         be_i,
    output logic [RegDw-1:0]           rdata_o,
    output logic                       ack_o,
    output logic                       error_o,
    input  logic                       lock_i,
    input  logic [NumRegs*RegDw-1:0]   hw_status_i,
    output logic [NumRegs*RegDw-1:0]   regs_o,
    output logic                       busy_o,
    output logic                       proto_err_o
);
    localparam int unsigned IdxW     = RegAw - 2;
    localparam int unsigned NumBytes = RegDw / 8;

    logic [NumRegs-1:0][RegDw-1:0] regs_q;
    logic [IdxW-1:0]               req_idx;
    logic                          req_any, req_both, dec_err, req_ro, wr_err, req_err;
    logic                          ready, wr_commit, pe_set, proto_err_q;

    function automatic logic [RegDw-1:0] read_lane(input logic [IdxW-1:0]             idx,
                                                   input logic [NumRegs-1:0][RegDw-1:0] regs,
                                                   input logic [NumRegs*RegDw-1:0]      hw);
        logic [RegDw-1:0] val;
        val = '0;
        for (int i = 0; i < NumRegs; i++) begin
            if (idx == IdxW'(i)) val = RoMask[i] ? hw[i*RegDw +: RegDw] : regs[i];
        end
        return val;
    endfunction

    assign req_idx  = addr_i[RegAw-1:2];
    assign req_any  = re_i | we_i;
    assign req_both = re_i & we_i;
    assign dec_err  = (addr_i[1:0] != 2'b00) || (32'(req_idx) >= NumRegs);

    always_comb begin
        req_ro = 1'b0;
        for (int i = 0; i < NumRegs; i++) begin
            if (req_idx == IdxW'(i)) req_ro = RoMask[i];
        end
    end

    assign wr_err  = dec_err | req_ro | lock_i | (be_i == '0);
    // Simultaneous read+write is answered as a failed read.
    assign req_err = req_both | (re_i ? dec_err : wr_err);

    assign wr_commit = req_any & ready & we_i & ~re_i & ~wr_err;
    assign pe_set    = req_both | (req_any & ~ready);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            regs_q <= '0;
        end else if (wr_commit) begin
            for (int i = 0; i < NumRegs; i++) begin
                if (req_idx == IdxW'(i)) begin
                    for (int b = 0; b < NumBytes; b++) begin
                        if (be_i[b]) regs_q[i][b*8 +: 8] <= wdata_i[b*8 +: 8];
                    end
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)     proto_err_q <= 1'b0;
        else if (pe_set) proto_err_q <= 1'b1;
    end

    assign proto_err_o = proto_err_q;

    for (genvar i = 0; i < NumRegs; i++) begin : g_regs_o
        assign regs_o[i*RegDw +: RegDw] = RoMask[i] ? '0 : regs_q[i];
    end

    if (AckLatency == 0) begin : g_comb
        assign ready   = 1'b1;
        assign busy_o  = 1'b0;
        assign ack_o   = req_any;
        assign error_o = req_any & req_err;
        assign rdata_o = (re_i & ~req_err) ? read_lane(req_idx, regs_q, hw_status_i) : '0;
    end else begin : g_fsm
        typedef enum logic [1:0] {
            IDLE = 2'd0,
            WAIT = 2'd1,
            ACK  = 2'd2
        } state_e;

        // WAIT is skipped entirely for a one-cycle latency.
        localparam logic [3:0] CntLoad = (AckLatency >= 2) ? 4'(AckLatency - 2) : 4'd0;

        state_e          state_q, state_d;
        logic [3:0]      cnt_q, cnt_d;
        logic [IdxW-1:0] idx_q, idx_d;
        logic            rd_q, rd_d, err_q, err_d;

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                state_q <= IDLE;
                cnt_q   <= '0;
                idx_q   <= '0;
                rd_q    <= 1'b0;
                err_q   <= 1'b0;
            end else begin
                state_q <= state_d;
                cnt_q   <= cnt_d;
                idx_q   <= idx_d;
                rd_q    <= rd_d;
                err_q   <= err_d;
            end
        end

        always_comb begin
            state_d = state_q;
            cnt_d   = cnt_q;
            idx_d   = idx_q;
            rd_d    = rd_q;
            err_d   = err_q;
            unique case (state_q)
                IDLE: begin
                    if (req_any) begin
                        idx_d   = req_idx;
                        rd_d    = re_i;
                        err_d   = req_err;
                        cnt_d   = CntLoad;
                        state_d = (AckLatency == 1) ? ACK : WAIT;
                    end
                end
                WAIT: begin
                    if (cnt_q == 4'd0) state_d = ACK;
                    else               cnt_d   = cnt_q - 4'd1;
                end
                ACK:     state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end

        assign ready   = (state_q == IDLE);
        assign busy_o  = (state_q != IDLE);
        assign ack_o   = (state_q == ACK);
        assign error_o = ack_o & err_q;
        // Status lanes are sampled in the ack cycle, not when the request was taken.
        assign rdata_o = (ack_o & rd_q & ~err_q) ? read_lane(idx_q, regs_q, hw_status_i) : '0;
    end
endmodule

// File: tb/tb_llki_reg_responder.sv
// Scoreboard bench for llki_reg_responder: four instances with latencies 1, 4, 0 and 3,
// directed scenarios followed by randomized traffic against a behavioural register model.
module tb_llki_reg_responder;
    localparam int NI = 4;
    localparam logic [15:0] RO = 16'h0088;

    function automatic int lat_of(input int k);
        case (k)
            0:       return 1;
            1:       return 4;
            2:       return 0;
            default: return 3;
        endcase
    endfunction

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        re_s   [NI];
    logic        we_s   [NI];
    logic        lock_s [NI];
    logic [7:0]  addr_s [NI];
    logic [31:0] wdata_s[NI];
    logic [3:0]  be_s   [NI];
    logic [511:0] hw_s  [NI];
    logic [511:0] regs_s[NI];
    logic [31:0] rdata_s[NI];
    logic        ack_s  [NI];
    logic        err_s  [NI];
    logic        busy_s [NI];
    logic        pe_s   [NI];

    for (genvar g = 0; g < NI; g++) begin : g_dut
        localparam int unsigned L = (g == 0) ? 1 : (g == 1) ? 4 : (g == 2) ? 0 : 3;
        llki_reg_responder #(
            .RegAw(8), .RegDw(32), .NumRegs(16), .AckLatency(L), .RoMask(RO)
        ) u_dut (
            .clk_i(clk), .rst_ni(rst_n), .re_i(re_s[g]), .we_i(we_s[g]),
            .addr_i(addr_s[g]), .wdata_i(wdata_s[g]), .be_i(be_s[g]),
            .rdata_o(rdata_s[g]), .ack_o(ack_s[g]), .error_o(err_s[g]),
            .lock_i(lock_s[g]), .hw_status_i(hw_s[g]), .regs_o(regs_s[g]),
            .busy_o(busy_s[g]), .proto_err_o(pe_s[g])
        );
    end

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // kind: 0 = compare rdata to val, 1 = rdata must equal hw lane at ack time, 2 = rdata unchecked
    typedef struct {
        int          inst;
        int          req;
        int          due;
        int          kind;
        int          lane;
        bit          err;
        logic [31:0] val;
    } exp_t;

    exp_t        q[$];
    logic [31:0] mem[NI][16];
    bit          exp_pe[NI];
    int          total = 0;
    int          bad = 0;

    task automatic check(input string nm, input int k, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s inst%0d cycle=%0d got=%h expected=%h", nm, k, cyc, act, req);
        end
    endtask

    function automatic logic [511:0] exp_regs(input int k);
        logic [511:0] v;
        v = '0;
        for (int i = 0; i < 16; i++) if (!RO[i]) v[i*32 +: 32] = mem[k][i];
        return v;
    endfunction

    function automatic int find_entry(input int k);
        for (int i = 0; i < q.size(); i++) if (q[i].inst == k) return i;
        return -1;
    endfunction

    always @(negedge clk) begin
        if (rst_n) begin
            for (int k = 0; k < NI; k++) begin
                int   pos;
                bit   eb;
                exp_t e;
                pos = find_entry(k);
                eb  = (pos >= 0) && (cyc > q[pos].req) && (cyc <= q[pos].due);
                check("busy", k, 32'(busy_s[k]), 32'(eb));
                check("proto_err", k, 32'(pe_s[k]), 32'(exp_pe[k]));
                if (ack_s[k]) begin
                    if (pos < 0) begin
                        check("unexpected_ack", k, 32'(ack_s[k]), 32'd0);
                    end else begin
                        e = q[pos];
                        q.delete(pos);
                        check("ack_cycle", k, 32'(cyc), 32'(e.due));
                        check("error", k, 32'(err_s[k]), 32'(e.err));
                        if (e.kind == 0)      check("rdata", k, rdata_s[k], e.val);
                        else if (e.kind == 1) check("rdata_ro", k, rdata_s[k], hw_s[k][e.lane*32 +: 32]);
                    end
                end else begin
                    check("idle_rdata", k, rdata_s[k], 32'd0);
                    check("idle_error", k, 32'(err_s[k]), 32'd0);
                    if (pos >= 0 && q[pos].due <= cyc) begin
                        check("missing_ack", k, 32'(ack_s[k]), 32'd1);
                        q.delete(pos);
                    end
                end
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Called at posedge+1; holds the request for one cycle, returns at the next posedge+1.
    task automatic req(input int k, input bit r, input bit w, input logic [7:0] a,
                       input logic [31:0] d, input logic [3:0] b, input bit lk);
        exp_t e;
        int   idx;
        bit   dec, ign;
        idx = int'(a[7:2]);
        dec = (a[1:0] != 2'b00) || (idx >= 16);
        ign = (lat_of(k) != 0) && (find_entry(k) >= 0);
        re_s[k] = r; we_s[k] = w; addr_s[k] = a; wdata_s[k] = d; be_s[k] = b; lock_s[k] = lk;
        if (!ign) begin
            e.inst = k; e.req = cyc; e.due = cyc + lat_of(k); e.lane = idx; e.val = '0;
            if (r) begin
                e.err  = dec || w;
                e.kind = w ? 2 : (dec ? 0 : (RO[idx] ? 1 : 0));
                if (!e.err) e.val = mem[k][idx];
            end else begin
                e.err  = dec || RO[idx[3:0]] || lk || (b == 4'h0);
                e.kind = 2;
                if (!e.err) begin
                    for (int j = 0; j < 4; j++) if (b[j]) mem[k][idx][j*8 +: 8] = d[j*8 +: 8];
                end
            end
            q.push_back(e);
        end
        @(posedge clk);
        #1;
        re_s[k] = 1'b0; we_s[k] = 1'b0;
        if (ign || (r && w)) exp_pe[k] = 1'b1;
        check("regs_o", k, 32'(regs_s[k] != exp_regs(k)), 32'd0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        q.delete();
        for (int k = 0; k < NI; k++) begin
            exp_pe[k] = 1'b0;
            for (int i = 0; i < 16; i++) mem[k][i] = '0;
        end
        idle(2);
        rst_n = 1'b1;
    endtask

    initial begin
        for (int k = 0; k < NI; k++) begin
            re_s[k] = 0; we_s[k] = 0; lock_s[k] = 0; addr_s[k] = '0; wdata_s[k] = '0; be_s[k] = '0;
            for (int i = 0; i < 16; i++) hw_s[k][i*32 +: 32] = $urandom();
        end
        #1;
        do_reset();
        for (int k = 0; k < NI; k++) check("reset_regs", k, 32'(regs_s[k] != 512'd0), 32'd0);
        idle(2);

        // Latency 1: full write, read back, partial write, error cases, read+write collision.
        req(0, 0, 1, 8'h04, 32'hDEADBEEF, 4'hF, 0);
        check("lane1_value", 0, regs_s[0][32 +: 32], 32'hDEADBEEF);
        idle(1);
        req(0, 1, 0, 8'h04, '0, 4'hF, 0);
        idle(1);
        req(0, 0, 1, 8'h08, 32'h11223344, 4'hF, 0);
        idle(1);
        req(0, 0, 1, 8'h08, 32'h0000AB00, 4'h2, 0);
        check("partial_value", 0, regs_s[0][64 +: 32], 32'h1122AB44);
        idle(1);
        req(0, 1, 0, 8'h08, '0, 4'hF, 0);           idle(1);
        req(0, 1, 0, 8'h40, '0, 4'hF, 0);           idle(1);
        req(0, 0, 1, 8'h06, 32'hFFFFFFFF, 4'hF, 0); idle(1);
        req(0, 0, 1, 8'h0C, 32'hFFFFFFFF, 4'hF, 0); idle(1);
        req(0, 0, 1, 8'h04, 32'h0, 4'hF, 1);        idle(1);
        req(0, 1, 1, 8'h04, 32'h12345678, 4'hF, 0); idle(2);

        // Latency 4: status lane changes between request and ack; request while busy.
        hw_s[1][3*32 +: 32] = 32'h5;
        req(1, 1, 0, 8'h0C, '0, 4'hF, 0);
        hw_s[1][3*32 +: 32] = 32'hA;
        idle(5);
        req(1, 1, 0, 8'h00, '0, 4'hF, 0);
        req(1, 1, 0, 8'h04, '0, 4'hF, 0);
        idle(6);

        // Latency 0: combinational ack.
        req(2, 0, 1, 8'h00, 32'h1, 4'hF, 0);
        check("l0_lane0", 2, regs_s[2][31:0], 32'h1);
        req(2, 1, 0, 8'h00, '0, 4'hF, 0);
        idle(2);

        // Latency 3: reset while waiting drops the ack and the committed write.
        req(3, 0, 1, 8'h10, 32'hCAFEF00D, 4'hF, 0);
        do_reset();
        idle(6);
        check("reset_drops_write", 3, regs_s[3][4*32 +: 32], 32'h0);

        for (int k = 0; k < NI; k++) begin
            for (int n = 0; n < 150; n++) begin
                int          op, sel;
                bit          r, w, lk;
                logic [7:0]  a;
                logic [3:0]  b;
                op  = $urandom_range(0, 9);
                r   = (op < 4) || (op == 9);
                w   = (op >= 4);
                sel = $urandom_range(0, 9);
                if (sel < 7)       a = {2'(0), 4'($urandom_range(0, 15)), 2'b00};
                else if (sel == 7) a = {2'(0), 4'($urandom_range(0, 15)), 2'($urandom_range(1, 3))};
                else if (sel == 8) a = {6'($urandom_range(16, 63)), 2'b00};
                else               a = 8'($urandom());
                b  = ($urandom_range(0, 7) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
                lk = ($urandom_range(0, 9) == 0);
                if ($urandom_range(0, 4) == 0) begin
                    for (int i = 0; i < 16; i++) hw_s[k][i*32 +: 32] = $urandom();
                end
                req(k, r, w, a, $urandom(), b, lk);
                idle($urandom_range(0, lat_of(k) + 1));
            end
            idle(lat_of(k) + 2);
        end

        check("queue_drained", 0, 32'(q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
